// File: rtl/avalon_enforcer_pkg.sv
// -----------------------------------------------------------------------------
// avalon_enforcer_pkg
// Shared types and helpers for the Avalon-ST packet enforcer.
//   enforcer_state_t : framing state (IDLE, IN_PKT, DROP)
//   empty_width()    : width of the Avalon-ST empty field for a given beat size
// -----------------------------------------------------------------------------
package avalon_enforcer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IN_PKT = 2'd1,
        DROP   = 2'd2
    } enforcer_state_t;

    // A one-byte beat has no meaningful empty value, but a zero-width vector
    // is illegal, so the field is kept at least one bit wide.
    function automatic int empty_width(input int bytes);
        return (bytes > 1) ? $clog2(bytes) : 1;
    endfunction

endpackage

// File: rtl/avalon_st_if.sv
// -----------------------------------------------------------------------------
// avalon_st_if
// Avalon-ST bundle with packet framing.
//   data  : 8*DATA_WIDTH_IN_BYTES bits of payload
//   valid : beat present
//   sop   : first beat of a packet
//   eop   : last beat of a packet
//   empty : number of unused bytes on an eop beat
//   rdy   : sink can accept a beat this cycle
// Modports: master drives the beat and reads rdy, slave does the opposite.
// -----------------------------------------------------------------------------
interface avalon_st_if #(
    parameter int DATA_WIDTH_IN_BYTES = 16
);
    localparam int DW = 8 * DATA_WIDTH_IN_BYTES;
    localparam int EW = avalon_enforcer_pkg::empty_width(DATA_WIDTH_IN_BYTES);

    logic [DW-1:0] data;
    logic          valid;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    logic          rdy;

    modport master (output data, output valid, output sop, output eop, output empty, input rdy);
    modport slave  (input data, input valid, input sop, input eop, input empty, output rdy);

endinterface

// File: rtl/sat_event_counter.sv
// -----------------------------------------------------------------------------
// sat_event_counter
// Saturating event counter with synchronous clear.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   inc   : count one event this cycle
//   clr   : clear to zero (has priority over inc)
//   count : current count, sticks at all-ones
// -----------------------------------------------------------------------------
module sat_event_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_WIDTH{1'b1}})) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/avalon_packet_enforcer.sv
// -----------------------------------------------------------------------------
// avalon_packet_enforcer
// Cleans sop/eop framing of an untrusted Avalon-ST stream, bounds packet
// length, sanitises empty, and re-times the stream through one output register
// with backpressure. Framing errors pulse an indicator and bump a saturating
// counter.
//   clk                 : system clock
//   rst                 : synchronous active-high reset
//   untrusted_msg       : input stream (slave)
//   enforced_msg        : cleaned output stream (master)
//   clear_counters      : synchronous clear of all error counters
//   missing_sop_indi    : pulse, beat dropped outside a packet (no sop)
//   unexpected_sop_indi : pulse, sop seen inside a packet
//   oversize_indi       : pulse, packet truncated at MAX_PKT_BEATS
//   *_cnt               : saturating counts of the above events
// -----------------------------------------------------------------------------
module avalon_packet_enforcer
    import avalon_enforcer_pkg::*;
#(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int MAX_PKT_BEATS       = 64,
    parameter int CNT_WIDTH           = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    avalon_st_if.slave           untrusted_msg,
    avalon_st_if.master          enforced_msg,
    input  logic                 clear_counters,
    output logic                 missing_sop_indi,
    output logic                 unexpected_sop_indi,
    output logic                 oversize_indi,
    output logic [CNT_WIDTH-1:0] missing_sop_cnt,
    output logic [CNT_WIDTH-1:0] unexpected_sop_cnt,
    output logic [CNT_WIDTH-1:0] oversize_cnt
);

    localparam int DW  = 8 * DATA_WIDTH_IN_BYTES;
    localparam int EW  = empty_width(DATA_WIDTH_IN_BYTES);
    localparam int BCW = $clog2(MAX_PKT_BEATS + 1);
    // beat_cnt holds the number of beats already forwarded, so the beat being
    // accepted is the last legal one when beat_cnt == MAX_PKT_BEATS-1.
    localparam logic [BCW-1:0] LAST_IDX = BCW'(MAX_PKT_BEATS - 1);

    // Event index into the indicator/counter arrays.
    localparam int EV_MISSING    = 0;
    localparam int EV_UNEXPECTED = 1;
    localparam int EV_OVERSIZE   = 2;

    enforcer_state_t state_q, state_d;
    logic [BCW-1:0]  beat_cnt_q, beat_cnt_d;

    logic            out_valid_q;
    logic [DW-1:0]   out_data_q;
    logic            out_sop_q;
    logic            out_eop_q;
    logic [EW-1:0]   out_empty_q;

    logic            in_rdy;
    logic            accept;
    logic            fwd;
    logic            fwd_sop;
    logic            fwd_eop;
    logic [EW-1:0]   fwd_empty;
    logic [2:0]      ev_d;
    logic [2:0]      indi_q;
    logic [CNT_WIDTH-1:0] cnt_w [3];

    // The output register can take a new beat when it is empty or draining
    // this cycle; this keeps full throughput without a skid buffer.
    assign in_rdy = !rst && (!out_valid_q || enforced_msg.rdy);
    assign accept = untrusted_msg.valid && in_rdy;

    // -------------------------------------------------------------------------
    // Next-state and forwarding decision
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        fwd        = 1'b0;
        fwd_sop    = 1'b0;
        fwd_eop    = 1'b0;
        fwd_empty  = untrusted_msg.empty;
        ev_d       = '0;

        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    if (!untrusted_msg.sop) begin
                        ev_d[EV_MISSING] = 1'b1;
                    end else begin
                        fwd     = 1'b1;
                        fwd_sop = 1'b1;
                        fwd_eop = untrusted_msg.eop;
                        if (!untrusted_msg.eop) begin
                            state_d    = IN_PKT;
                            beat_cnt_d = BCW'(1);
                        end
                    end
                end

                IN_PKT: begin
                    // A stray sop is flattened into a continuation beat and
                    // remains subject to the eop and length rules below.
                    fwd = 1'b1;
                    if (untrusted_msg.sop) begin
                        ev_d[EV_UNEXPECTED] = 1'b1;
                    end
                    if (untrusted_msg.eop) begin
                        fwd_eop    = 1'b1;
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                    end else if (beat_cnt_q == LAST_IDX) begin
                        fwd_eop             = 1'b1;
                        fwd_empty           = '0;
                        ev_d[EV_OVERSIZE]   = 1'b1;
                        state_d             = DROP;
                        beat_cnt_d          = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BCW'(1);
                    end
                end

                DROP: begin
                    if (untrusted_msg.eop) begin
                        state_d = IDLE;
                    end
                end

                default: begin
                    state_d    = IDLE;
                    beat_cnt_d = '0;
                end
            endcase
        end

        // Only an end-of-packet beat may carry a non-zero empty.
        if (!fwd_eop) begin
            fwd_empty = '0;
        end
    end

    // -------------------------------------------------------------------------
    // State, output register and indicator pulses
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_empty_q <= '0;
            indi_q      <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            indi_q     <= ev_d;
            // When in_rdy is low the register is stalled and holds its beat.
            if (in_rdy) begin
                out_valid_q <= fwd;
                if (fwd) begin
                    out_data_q  <= untrusted_msg.data;
                    out_sop_q   <= fwd_sop;
                    out_eop_q   <= fwd_eop;
                    out_empty_q <= fwd_empty;
                end
            end
        end
    end

    assign untrusted_msg.rdy  = in_rdy;
    assign enforced_msg.valid = out_valid_q;
    assign enforced_msg.data  = out_data_q;
    assign enforced_msg.sop   = out_sop_q;
    assign enforced_msg.eop   = out_eop_q;
    assign enforced_msg.empty = out_empty_q;

    assign missing_sop_indi    = indi_q[EV_MISSING];
    assign unexpected_sop_indi = indi_q[EV_UNEXPECTED];
    assign oversize_indi       = indi_q[EV_OVERSIZE];

    // -------------------------------------------------------------------------
    // Error counters: they see the raw event so their new value appears in the
    // same cycle as the registered indicator pulse.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            sat_event_counter #(
                .CNT_WIDTH(CNT_WIDTH)
            ) u_cnt (
                .clk  (clk),
                .rst  (rst),
                .inc  (ev_d[gi]),
                .clr  (clear_counters),
                .count(cnt_w[gi])
            );
        end
    endgenerate

    assign missing_sop_cnt    = cnt_w[EV_MISSING];
    assign unexpected_sop_cnt = cnt_w[EV_UNEXPECTED];
    assign oversize_cnt       = cnt_w[EV_OVERSIZE];

endmodule

// File: tb/tb_avalon_packet_enforcer.sv
// -----------------------------------------------------------------------------
// tb_avalon_packet_enforcer
// Directed bench: MAX_PKT_BEATS = 4, CNT_WIDTH = 2, 16-byte beats.
// -----------------------------------------------------------------------------
module tb_avalon_packet_enforcer;

    localparam int BYTES = 16;
    localparam int MAXB  = 4;
    localparam int CW    = 2;

    typedef struct {
        logic [127:0] data;
        logic         sop;
        logic         eop;
        logic [3:0]   empty;
    } beat_t;

    logic clk;
    logic rst;
    logic clear_counters;
    logic missing_sop_indi, unexpected_sop_indi, oversize_indi;
    logic [CW-1:0] missing_sop_cnt, unexpected_sop_cnt, oversize_cnt;

    avalon_st_if #(.DATA_WIDTH_IN_BYTES(BYTES)) up_if ();
    avalon_st_if #(.DATA_WIDTH_IN_BYTES(BYTES)) dn_if ();

    avalon_packet_enforcer #(
        .DATA_WIDTH_IN_BYTES(BYTES),
        .MAX_PKT_BEATS      (MAXB),
        .CNT_WIDTH          (CW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .untrusted_msg      (up_if),
        .enforced_msg       (dn_if),
        .clear_counters     (clear_counters),
        .missing_sop_indi   (missing_sop_indi),
        .unexpected_sop_indi(unexpected_sop_indi),
        .oversize_indi      (oversize_indi),
        .missing_sop_cnt    (missing_sop_cnt),
        .unexpected_sop_cnt (unexpected_sop_cnt),
        .oversize_cnt       (oversize_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Monitor state (written only by the monitor process).
    beat_t cap[$];
    int    miss_n = 0;
    int    unexp_n = 0;
    int    over_n = 0;

    // Sampled on the falling edge: a valid&&rdy seen here transfers at the
    // next rising edge, and all bench drives happen 1 ns after a rising edge.
    always @(negedge clk) begin
        if (dn_if.valid && dn_if.rdy) begin
            cap.push_back('{dn_if.data, dn_if.sop, dn_if.eop, dn_if.empty});
            $display("out beat data=%0d sop=%0b eop=%0b empty=%0d",
                     dn_if.data[63:0], dn_if.sop, dn_if.eop, dn_if.empty);
        end
        if (missing_sop_indi)    miss_n++;
        if (unexpected_sop_indi) unexp_n++;
        if (oversize_indi)       over_n++;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("check %s ok (%0d)", tag, obs);
        end
    endtask

    task automatic wait_accept(input string tag);
        bit done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (up_if.rdy) done = 1;
            @(posedge clk);
            #1;
        end
        if (!done) check_val({tag, "_accept_timeout"}, 64'(up_if.rdy), 64'd1);
        up_if.valid = 1'b0;
    endtask

    task automatic drive(input logic [127:0] d, input logic s, input logic e, input logic [3:0] emp);
        up_if.data  = d;
        up_if.sop   = s;
        up_if.eop   = e;
        up_if.empty = emp;
        up_if.valid = 1'b1;
    endtask

    task automatic send(input logic [127:0] d, input logic s, input logic e, input logic [3:0] emp);
        drive(d, s, e, emp);
        wait_accept("send");
        $display("in beat data=%0d sop=%0b eop=%0b empty=%0d", d[63:0], s, e, emp);
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_beat(input string tag, input int idx, input logic [63:0] d,
                              input logic s, input logic e, input logic [3:0] emp);
        if (idx >= cap.size()) begin
            check_val({tag, "_present"}, 64'(cap.size()), 64'(idx + 1));
        end else begin
            check_val({tag, "_data"},  cap[idx].data[63:0], d);
            check_val({tag, "_sop"},   64'(cap[idx].sop), 64'(s));
            check_val({tag, "_eop"},   64'(cap[idx].eop), 64'(e));
            check_val({tag, "_empty"}, 64'(cap[idx].empty), 64'(emp));
        end
    endtask

    int b0, m0, u0, o0;

    task automatic snap();
        b0 = cap.size();
        m0 = miss_n;
        u0 = unexp_n;
        o0 = over_n;
    endtask

    initial begin
        rst            = 1'b1;
        clear_counters = 1'b0;
        dn_if.rdy      = 1'b1;
        up_if.valid    = 1'b0;
        up_if.data     = '0;
        up_if.sop      = 1'b0;
        up_if.eop      = 1'b0;
        up_if.empty    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_out_valid", 64'(dn_if.valid), 64'd0);
        check_val("rst_in_rdy",    64'(up_if.rdy), 64'd0);
        check_val("rst_out_data",  dn_if.data[63:0], 64'd0);
        check_val("rst_miss_cnt",  64'(missing_sop_cnt), 64'd0);
        check_val("rst_over_cnt",  64'(oversize_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Missing sop: two orphan beats then a 3-beat packet.
        snap();
        send(1, 0, 0, 0);
        send(2, 0, 0, 0);
        send(34, 1, 0, 0);
        send(34, 0, 0, 0);
        send(34, 0, 1, 3);
        drain();
        check_val("miss_pulses", 64'(miss_n - m0), 64'd2);
        check_val("miss_cnt",    64'(missing_sop_cnt), 64'd2);
        check_val("miss_beats",  64'(cap.size() - b0), 64'd3);
        check_beat("miss_b0", b0 + 0, 34, 1, 0, 0);
        check_beat("miss_b1", b0 + 1, 34, 0, 0, 0);
        check_beat("miss_b2", b0 + 2, 34, 0, 1, 3);

        // Unexpected sop on beat 3 of 4.
        snap();
        send(10, 1, 0, 0);
        send(11, 0, 0, 0);
        send(12, 1, 0, 0);
        send(13, 0, 1, 5);
        drain();
        check_val("unexp_pulses", 64'(unexp_n - u0), 64'd1);
        check_val("unexp_cnt",    64'(unexpected_sop_cnt), 64'd1);
        check_val("unexp_beats",  64'(cap.size() - b0), 64'd4);
        check_beat("unexp_b0", b0 + 0, 10, 1, 0, 0);
        check_beat("unexp_b2", b0 + 2, 12, 0, 0, 0);
        check_beat("unexp_b3", b0 + 3, 13, 0, 1, 5);

        // Oversize: 7-beat packet truncated at beat 4, then a clean 2-beat one.
        snap();
        send(20, 1, 0, 0);
        send(21, 0, 0, 0);
        send(22, 0, 0, 0);
        send(23, 0, 0, 9);
        send(24, 1, 0, 0);
        send(25, 0, 0, 0);
        send(26, 0, 1, 7);
        send(30, 1, 0, 0);
        send(31, 0, 1, 2);
        drain();
        check_val("over_pulses", 64'(over_n - o0), 64'd1);
        check_val("over_cnt",    64'(oversize_cnt), 64'd1);
        check_val("over_miss",   64'(miss_n - m0), 64'd0);
        check_val("over_beats",  64'(cap.size() - b0), 64'd6);
        check_beat("over_b3",  b0 + 3, 23, 0, 1, 0);
        check_beat("over_p2a", b0 + 4, 30, 1, 0, 0);
        check_beat("over_p2b", b0 + 5, 31, 0, 1, 2);

        // Exact length: eop on beat MAX_PKT_BEATS.
        snap();
        send(40, 1, 0, 0);
        send(41, 0, 0, 0);
        send(42, 0, 0, 0);
        send(43, 0, 1, 1);
        drain();
        check_val("exact_over", 64'(over_n - o0), 64'd0);
        check_val("exact_beats", 64'(cap.size() - b0), 64'd4);
        check_beat("exact_b3", b0 + 3, 43, 0, 1, 1);

        // Backpressure: stall the output for 5 cycles with a beat waiting.
        snap();
        send(50, 1, 0, 0);
        dn_if.rdy = 1'b0;
        drive(51, 0, 0, 0);
        repeat (5) begin
            @(negedge clk);
            check_val("bp_in_rdy",    64'(up_if.rdy), 64'd0);
            check_val("bp_out_valid", 64'(dn_if.valid), 64'd1);
            check_val("bp_out_data",  dn_if.data[63:0], 64'd50);
            check_val("bp_out_sop",   64'(dn_if.sop), 64'd1);
            @(posedge clk);
            #1;
        end
        dn_if.rdy = 1'b1;
        wait_accept("bp");
        send(52, 0, 1, 6);
        drain();
        check_val("bp_beats", 64'(cap.size() - b0), 64'd3);
        check_beat("bp_b0", b0 + 0, 50, 1, 0, 0);
        check_beat("bp_b1", b0 + 1, 51, 0, 0, 0);
        check_beat("bp_b2", b0 + 2, 52, 0, 1, 6);

        // Empty sanitising on a non-eop beat.
        snap();
        send(60, 1, 0, 15);
        send(61, 0, 1, 15);
        drain();
        check_beat("empty_b0", b0 + 0, 60, 1, 0, 0);
        check_beat("empty_b1", b0 + 1, 61, 0, 1, 15);

        // Saturation: 5 more missing-sop events on top of the existing 2.
        for (int i = 0; i < 5; i++) send(64'(70 + i), 0, 0, 0);
        drain();
        check_val("sat_miss_cnt", 64'(missing_sop_cnt), 64'd3);

        // Clear coincident with an event: clear wins, pulse still happens.
        snap();
        clear_counters = 1'b1;
        send(80, 0, 0, 0);
        clear_counters = 1'b0;
        drain();
        check_val("clr_miss_pulse", 64'(miss_n - m0), 64'd1);
        check_val("clr_miss_cnt",   64'(missing_sop_cnt), 64'd0);
        check_val("clr_unexp_cnt",  64'(unexpected_sop_cnt), 64'd0);
        check_val("clr_over_cnt",   64'(oversize_cnt), 64'd0);

        // Reset mid-packet: next beat without sop is judged from IDLE.
        snap();
        send(90, 1, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(91, 0, 0, 0);
        drain();
        check_val("rstmid_beats", 64'(cap.size() - b0), 64'd1);
        check_val("rstmid_miss",  64'(miss_n - m0), 64'd1);
        check_val("rstmid_cnt",   64'(missing_sop_cnt), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
